// File: rtl/conditionare_senzor_linie.sv
// rtl/conditionare_senzor_linie.sv - IR line-sensor front end: sync, debounce, line-present level, sample and 1 Hz ticks
// Enable-based timebase on the board clock; all outputs come from registered state.
module conditionare_senzor_linie #(
    parameter int CLK_HZ       = 50000000,
    parameter int SAMPLE_HZ    = 1000,
    parameter int DEBOUNCE_CNT = 8,
    parameter int N_SENS       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] senzor_in,
    output logic [N_SENS-1:0] senzor_stabil,
    output logic              semnal,
    output logic              pierdut_puls,
    output logic              tick_esantion,
    output logic              tick_1hz
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW  = (SAMPLE_HZ > 1) ? $clog2(SAMPLE_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [HW-1:0] HZ_MAX  = HW'(SAMPLE_HZ - 1);
    localparam logic [7:0]    DEB_MAX = 8'(DEBOUNCE_CNT);

    logic [N_SENS-1:0] sync1_q, sync2_q;
    logic [PW-1:0]     pre_q, pre_d;
    logic [HW-1:0]     hz_q, hz_d;
    logic              tick_s_q, tick_s_d;
    logic              tick_h_q, tick_h_d;
    logic [7:0]        deb_q [N_SENS];
    logic [7:0]        deb_d [N_SENS];
    logic [N_SENS-1:0] stabil_q, stabil_d;
    logic              semnal_q, semnal_prev_q;
    logic              pre_wrap, hz_wrap;
    logic [7:0]        inc;

    always_comb begin
        pre_wrap = (pre_q == PRE_MAX);
        hz_wrap  = (hz_q == HZ_MAX);
        pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
        tick_s_d = pre_wrap;
        hz_d     = hz_q;
        tick_h_d = 1'b0;
        // The 1 Hz count advances alongside the sample tick being issued, so both pulses coincide.
        if (pre_wrap) begin
            hz_d     = hz_wrap ? '0 : hz_q + 1'b1;
            tick_h_d = hz_wrap;
        end
    end

    always_comb begin
        inc      = '0;
        stabil_d = stabil_q;
        for (int i = 0; i < N_SENS; i++) begin
            deb_d[i] = deb_q[i];
            inc      = (deb_q[i] == 8'hFF) ? deb_q[i] : deb_q[i] + 8'd1;
            if (tick_s_q) begin
                if (sync2_q[i] == stabil_q[i]) begin
                    deb_d[i] = '0;
                end else if (inc >= DEB_MAX) begin
                    deb_d[i]    = '0;
                    stabil_d[i] = sync2_q[i];
                end else begin
                    deb_d[i] = inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            pre_q         <= '0;
            hz_q          <= '0;
            tick_s_q      <= 1'b0;
            tick_h_q      <= 1'b0;
            stabil_q      <= '0;
            semnal_q      <= 1'b0;
            semnal_prev_q <= 1'b0;
            for (int i = 0; i < N_SENS; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            sync1_q       <= senzor_in;
            sync2_q       <= sync1_q;
            pre_q         <= pre_d;
            hz_q          <= hz_d;
            tick_s_q      <= tick_s_d;
            tick_h_q      <= tick_h_d;
            stabil_q      <= stabil_d;
            semnal_q      <= |stabil_q;
            semnal_prev_q <= semnal_q;
            for (int i = 0; i < N_SENS; i++) begin
                deb_q[i] <= deb_d[i];
            end
        end
    end

    assign senzor_stabil = stabil_q;
    assign semnal        = semnal_q;
    assign pierdut_puls  = semnal_prev_q & ~semnal_q;
    assign tick_esantion = tick_s_q;
    assign tick_1hz      = tick_h_q;

endmodule

// File: tb/tb_conditionare_senzor_linie.sv
// tb/tb_conditionare_senzor_linie.sv - directed self-checking bench for conditionare_senzor_linie
module tb_conditionare_senzor_linie;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] senzor_in;
    logic [2:0] senzor_stabil;
    logic       semnal, pierdut_puls, tick_esantion, tick_1hz;

    int   cyc, n_tick, n_puls, puls_bad, n_checks, n_pass, odd, sem_low;
    logic sem_prev;

    conditionare_senzor_linie #(
        .CLK_HZ(1000), .SAMPLE_HZ(100), .DEBOUNCE_CNT(3), .N_SENS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .senzor_in(senzor_in),
        .senzor_stabil(senzor_stabil), .semnal(semnal), .pierdut_puls(pierdut_puls),
        .tick_esantion(tick_esantion), .tick_1hz(tick_1hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (tick_esantion) n_tick++;
        if (pierdut_puls) begin
            n_puls++;
            if (!(sem_prev && !semnal)) puls_bad++;
        end
        sem_prev = semnal;
    endtask

    task automatic align();
        for (int k = 0; k < 20 && !tick_esantion; k++) step();
        step();
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; n_tick = 0; n_puls = 0; puls_bad = 0;
        sem_prev  = 1'b0;
        rst_n     = 1'b0;
        senzor_in = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_stabil", senzor_stabil, 0);
        check("rst_semnal", semnal, 0);
        check("rst_pierdut", pierdut_puls, 0);
        check("rst_tick", tick_esantion, 0);
        check("rst_tick1hz", tick_1hz, 0);

        senzor_in = 3'b000;
        rst_n = 1'b1;
        cyc = 0; n_tick = 0;
        for (int k = 0; k < 30 && !tick_esantion; k++) step();
        check("first_tick_cycle", cyc, 10);
        for (int k = 0; k < 1100 && !tick_1hz; k++) step();
        check("tick1hz_cycle", cyc, 1000);
        check("tick1hz_sample_count", n_tick, 100);
        check("tick1hz_coincident", tick_esantion, 1);

        // debounce accept
        align();
        senzor_in = 3'b010; n_tick = 0; n_puls = 0;
        for (int k = 0; k < 60 && senzor_stabil != 3'b010; k++) step();
        check("accept_stabil", senzor_stabil, 3'b010);
        check("accept_cycle", cyc, 1031);
        check("accept_samples", n_tick, 3);
        check("accept_semnal_lag", semnal, 0);
        step();
        check("accept_semnal", semnal, 1);
        check("accept_no_pulse", n_puls, 0);

        // handover 010 -> 100 with no gap
        align();
        senzor_in = 3'b100; n_puls = 0; odd = 0; sem_low = 0;
        for (int k = 0; k < 60 && senzor_stabil != 3'b100; k++) begin
            step();
            if (senzor_stabil != 3'b010 && senzor_stabil != 3'b100) odd++;
            if (!semnal) sem_low++;
        end
        repeat (3) begin
            step();
            if (!semnal) sem_low++;
        end
        check("handover_stabil", senzor_stabil, 3'b100);
        check("handover_same_tick", odd, 0);
        check("handover_semnal_held", sem_low, 0);
        check("handover_no_pulse", n_puls, 0);

        // line loss 100 -> 000
        align();
        senzor_in = 3'b000; n_tick = 0; n_puls = 0; puls_bad = 0;
        for (int k = 0; k < 60 && senzor_stabil != 3'b000; k++) step();
        check("loss_samples", n_tick, 3);
        repeat (4) step();
        check("loss_semnal", semnal, 0);
        check("loss_pulse_count", n_puls, 1);
        check("loss_pulse_timing", puls_bad, 0);

        // glitch of 2 sample periods is rejected
        align();
        senzor_in = 3'b001; n_puls = 0; odd = 0;
        repeat (20) begin
            step();
            if (senzor_stabil != 3'b000 || semnal) odd++;
        end
        senzor_in = 3'b000;
        repeat (40) begin
            step();
            if (senzor_stabil != 3'b000 || semnal) odd++;
        end
        check("glitch_no_change", odd, 0);
        check("glitch_no_pulse", n_puls, 0);

        // async reset in the middle of a debounce
        align();
        senzor_in = 3'b011;
        for (int k = 0; k < 60 && senzor_stabil != 3'b011; k++) step();
        check("pre_async_stabil", senzor_stabil, 3'b011);
        senzor_in = 3'b000; n_tick = 0;
        for (int k = 0; k < 40 && n_tick < 2; k++) step();
        step();
        check("pre_async_semnal", semnal, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_stabil", senzor_stabil, 0);
        check("async_semnal", semnal, 0);
        check("async_pierdut", pierdut_puls, 0);
        repeat (2) step();
        senzor_in = 3'b011;
        sem_prev = 1'b0;
        rst_n = 1'b1;
        cyc = 0; n_tick = 0; n_puls = 0;
        for (int k = 0; k < 60 && senzor_stabil != 3'b011; k++) step();
        check("restart_cycle", cyc, 31);
        check("restart_samples", n_tick, 3);
        check("restart_no_pulse", n_puls, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conditionare_senzor_linie.md
Name: conditionare_senzor_linie

Overview:
- Front end of the line-follower sensing path: samples raw IR line-sensor bits, synchronises and debounces them, and produces the level `semnal` (line present).
- Also produces a 1 Hz single-cycle tick and a "line lost" pulse.
- Feeds the downstream lost-line hold timer, which consumes `semnal` and the 1 Hz tick.
- Replaces ad-hoc clock division with a clean enable-based timebase on the board clock.

Parameters:
- CLK_HZ, 50000000, board clock frequency in Hz.
- SAMPLE_HZ, 1000, sensor sampling rate in Hz; CLK_HZ must be an integer multiple of SAMPLE_HZ.
- DEBOUNCE_CNT, 8, consecutive agreeing samples needed to change a stable bit (range 1..255).
- N_SENS, 3, number of sensor inputs (1..8).

Ports:
- clk  input  1  board clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- senzor_in  input  N_SENS  raw sensor bits, asynchronous to clk; 1 = line under sensor.
- senzor_stabil  output  N_SENS  debounced sensor bits.
- semnal  output  1  line present = OR of senzor_stabil, registered.
- pierdut_puls  output  1  one-cycle pulse on the 1->0 transition of semnal.
- tick_esantion  output  1  one-cycle pulse at SAMPLE_HZ.
- tick_1hz  output  1  one-cycle pulse at 1 Hz.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; synchroniser flops, debounce counters and prescalers cleared.
  - Reset released mid-operation restarts every count from 0; no pulse is emitted at reset release.
- Synchroniser: two flops per bit. Synchronised bit `s` lags senzor_in by 2 clk cycles.
- Sample prescaler:
  - Counts 0..CLK_HZ/SAMPLE_HZ-1.
  - tick_esantion = 1 for the cycle in which the counter wraps to 0.
  - First tick occurs CLK_HZ/SAMPLE_HZ cycles after reset release.
- 1 Hz prescaler:
  - Counts tick_esantion events 0..SAMPLE_HZ-1.
  - tick_1hz asserts in the same cycle as the tick_esantion that wraps the counter, so it is coincident with a sample tick.
- Debounce, per bit, evaluated only on a tick_esantion cycle:
  - If s == senzor_stabil[i]: counter cleared to 0.
  - Else: counter increments.
  - When the incremented value reaches DEBOUNCE_CNT: senzor_stabil[i] toggles to s and the counter clears, registered in that same cycle.
  - A glitch shorter than DEBOUNCE_CNT samples never changes senzor_stabil; any agreeing sample resets progress.
  - The counter saturates, so no wrap-around is possible.
- semnal: registered OR of senzor_stabil, one cycle after senzor_stabil changes.
- pierdut_puls:
  - 1 for exactly one cycle, the cycle after semnal goes 1->0. Implemented from a registered previous value of semnal.
  - No pulse on a 0->1 transition.
- Simultaneous events: several bits toggling on the same sample tick is allowed; semnal reflects the combined OR, so a handover between sensors with no gap produces no pierdut_puls.
- Latency (raw edge held stable -> semnal): 2 sync cycles + up to DEBOUNCE_CNT sample periods + 2 cycles.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=1000, SAMPLE_HZ=100, DEBOUNCE_CNT=3, N_SENS=3.
- Reset: hold rst_n=0 with senzor_in=3'b111 -> all outputs 0. Release -> first tick_esantion at cycle 10, tick_1hz at cycle 1000 coincident with the 100th tick_esantion.
- Debounce accept: set senzor_in=3'b010 and hold -> senzor_stabil=3'b010 on the 3rd sample tick after sync (about cycle 30), semnal=1 one cycle later, pierdut_puls stays 0.
- Glitch reject: with stable 3'b000, pulse senzor_in=3'b001 for 2 sample periods (20 cycles) -> senzor_stabil, semnal and pierdut_puls remain 0.
- Line loss: from stable 3'b100, drive 3'b000 -> after 3 samples senzor_stabil=0, semnal falls, pierdut_puls=1 for exactly 1 cycle.
- Handover: change 3'b100 to 3'b010 in one clock -> both bits update on the same tick, semnal stays 1, no pierdut_puls.
- Async reset mid-debounce: after 2 of 3 disagreeing samples assert rst_n=0 asynchronously (between clk edges) -> outputs 0 immediately. After release, the full 3 new samples are needed before senzor_stabil changes.
